acs_error_recovery_16: RTL and testbench

- Variable-latency exact adder built around an almost-correct (windowed-carry) 16-bit speculative adder.
- Accepts operand pairs over a valid/ready handshake and computes a speculative sum in one cycle.
- A conservative detector flags possible carry-speculation failure; flagged operations spend one extra cycle in exact correction.
- Produces the exact result on a valid/ready output handshake.
- Sits between an operand producer and a result consumer; counts recovered operations for error-rate measurement.

---
 rtl/acs_error_recovery_16.sv | 89 ++++++++
 tb/tb_acs_error_recovery_16.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/acs_error_recovery_16.sv
// acs_error_recovery_16: windowed-carry speculative adder with one-cycle exact correction on detected speculation risk
module acs_error_recovery_16 #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, SPEC, CORR, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, p, g, spec_sum, ex_sum;
  logic spec_cout, ex_cout, det, carry;
  assign p = a_r ^ b_r;
  assign g = a_r & b_r;
  assign {ex_cout, ex_sum} = {1'b0, a_r} + {1'b0, b_r};
  // Speculative sum: each bit's carry sees only the WINDOW bits below it, starting from carry-in 0
  always_comb begin
    spec_sum = '0;
    spec_cout = 1'b0;
    carry = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      carry = 1'b0;
      for (int j = 0; j < WIDTH; j++)
        if (j < i && j + WINDOW >= i) carry = g[j] | (p[j] & carry);
      if (i < WIDTH) spec_sum[i] = p[i] ^ carry;
      else spec_cout = carry;
    end
  end
  // Detector: a WINDOW-long propagate run above bit 0 may carry a truncated chain, so force correction
  always_comb begin
    det = 1'b0;
    for (int k = 1; k + WINDOW - 1 <= WIDTH - 1; k++) det = det | (&p[k +: WINDOW]);
  end
  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      err_flag <= 1'b0;
      err_count <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          in_ready <= 1'b0;
          state <= SPEC;
        end
        SPEC: if (det) state <= CORR;
        else begin
          sum <= spec_sum;
          cout <= spec_cout;
          err_flag <= 1'b0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        CORR: begin
          sum <= ex_sum;
          cout <= ex_cout;
          err_flag <= 1'b1;
          err_count <= &err_count ? err_count : err_count + 1'b1;
          out_valid <= 1'b1;
          state <= DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_acs_error_recovery_16.sv
// tb_acs_error_recovery_16: scoreboard bench with directed vectors; a second instance with a 2-bit counter checks saturation
module tb_acs_error_recovery_16;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, cout, err_flag;
  logic [15:0] sum, err_count;
  logic s_in_ready, s_out_valid, s_cout, s_err_flag;
  logic [15:0] s_sum;
  logic [1:0] s_err_count;
  int total = 0, bad = 0, cyc = 0, first_cyc = 0, cnt = 0;
  logic prev_ov = 0;
  typedef struct {
    logic [15:0] sum;
    logic cout;
    logic flag;
    int cnt;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];

  acs_error_recovery_16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .err_flag(err_flag), .err_count(err_count)
  );
  acs_error_recovery_16 #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout),
    .err_flag(s_err_flag), .err_count(s_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the expected result on every output handshake; latency counts the cycle after the accept edge as 1
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 0;
    else begin
      if (out_valid && !prev_ov) first_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("err_flag", err_flag, e.flag);
          chk("err_count", err_count, e.cnt);
          chk("err_count_sat2", s_err_count, e.cnt > 3 ? 3 : e.cnt);
          chk("latency", first_cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    logic ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] es, input logic ec, input logic ef);
    exp_t e;
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    if (ef) cnt++;
    e.sum = es; e.cout = ec; e.flag = ef; e.cnt = cnt; e.lat = ef ? 3 : 2; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] es, input logic ec, input logic ef);
    wait_idle();
    issue(x, y, es, ec, ef);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_err_flag"}, err_flag, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_count_sat2"}, s_err_count, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;
    op(16'd52, 16'd66, 16'd118, 0, 0);
    op(16'd255, 16'd1, 16'd256, 0, 1);
    op(16'd31728, 16'd32650, 16'd64378, 0, 1);
    op(16'd512, 16'd512, 16'd1024, 0, 0);
    op(16'd65535, 16'd1, 16'd0, 1, 1);
    // Backpressure: result must be held unchanged while the consumer stalls
    wait_idle();
    out_ready = 0;
    issue(16'd50, 16'd40, 16'd90, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 90);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    // Reset while the flagged operation sits in correction: it must vanish
    wait_idle();
    a = 16'd255;
    b = 16'd1;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    cnt = 0;
    #1 chk_reset_outputs("midcorr_reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_out_after_reset", out_valid, 0);
    end
    op(16'd3, 16'd4, 16'd7, 0, 0);
    for (int i = 0; i < 5; i++) op(16'd255, 16'd1, 16'd256, 0, 1);
    wait_idle();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
